// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared types, MMIO offsets and address decode for cpu_mem_responder
package cpu_mem_pkg;
  localparam int PKG_ADDR_W = 10;
  localparam logic [3:0] CON_OFS = 4'h0;
  localparam logic [3:0] HALT_OFS = 4'h4;
  typedef struct packed {
    logic valid;
    logic [PKG_ADDR_W-3:0] idx;
    logic [31:0] data;
  } sb_entry_t;
  function automatic logic [PKG_ADDR_W-3:0] word_idx(input logic [31:0] addr);
    return (PKG_ADDR_W-2)'(addr >> 2);
  endfunction
endpackage

// File: rtl/cpu_store_buffer.sv
// cpu_store_buffer: circular posting store buffer with in-order drain and youngest-match forwarding
module cpu_store_buffer
  import cpu_mem_pkg::*;
#(
  parameter int SB_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic stall,
  input  logic [PKG_ADDR_W-3:0] push_idx,
  input  logic [31:0] push_data,
  input  logic [PKG_ADDR_W-3:0] lookup_idx,
  output logic drain,
  output logic drop,
  output logic hit,
  output logic [31:0] hit_data,
  output sb_entry_t head_entry,
  output logic [$clog2(SB_DEPTH+1)-1:0] count,
  output logic full
);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = $clog2(SB_DEPTH+1);
  sb_entry_t ent [SB_DEPTH];
  logic [PW-1:0] head, tail;
  logic accept;
  assign full = count == CW'(SB_DEPTH);
  assign drain = count != '0 && !stall;
  assign accept = push && (!full || drain);
  assign drop = push && full && !drain;
  assign head_entry = ent[head];
  // scan oldest to youngest so the youngest matching entry wins
  always_comb begin
    hit = 1'b0;
    hit_data = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (ent[head + PW'(i)].valid && ent[head + PW'(i)].idx == lookup_idx) begin
        hit = 1'b1;
        hit_data = ent[head + PW'(i)].data;
      end
    end
  end
  // pointers and entries; a push into the slot being drained overrides its valid clear
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int i = 0; i < SB_DEPTH; i++) ent[i] <= '0;
    end else begin
      if (drain) begin
        ent[head].valid <= 1'b0;
        head <= head + 1'b1;
      end
      if (accept) begin
        ent[tail] <= '{valid: 1'b1, idx: push_idx, data: push_data};
        tail <= tail + 1'b1;
      end
      count <= count + CW'(accept) - CW'(drain);
    end
endmodule

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: word RAM behind a posting store buffer with loader port; debug MMIO under CPU_MEM_DBG_MMIO_EN
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int SB_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_FFF0
) (
  input  logic clk,
  input  logic reset,
  input  logic [31:0] cpu_addr,
  input  logic cpu_we,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  input  logic ld_en,
  input  logic [ADDR_W-3:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic [$clog2(SB_DEPTH+1)-1:0] sb_count,
  output logic sb_full,
  output logic overflow,
  output logic err_misaligned,
  output logic con_valid,
  output logic [7:0] con_data,
  output logic halt
);
  logic [31:0] ram [2**(ADDR_W-2)];
  logic [ADDR_W-3:0] idx;
  logic aligned, mmio, drain, drop, hit, unused_valid;
  logic [31:0] hit_data;
  sb_entry_t head_entry;
  assign idx = word_idx(cpu_addr);
  assign aligned = cpu_addr[1:0] == 2'b00;
  assign unused_valid = head_entry.valid;
`ifdef CPU_MEM_DBG_MMIO_EN
  assign mmio = cpu_addr[31:4] == MMIO_BASE[31:4];
  // console byte strobe and sticky halt from aligned stores into the debug window
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      con_valid <= 1'b0;
      con_data <= '0;
      halt <= 1'b0;
    end else begin
      con_valid <= cpu_we && aligned && mmio && cpu_addr[3:0] == CON_OFS;
      if (cpu_we && aligned && mmio && cpu_addr[3:0] == CON_OFS) con_data <= cpu_wdata[7:0];
      if (cpu_we && aligned && mmio && cpu_addr[3:0] == HALT_OFS) halt <= 1'b1;
    end
`else
  logic unused_mmio;
  assign unused_mmio = ^{MMIO_BASE, CON_OFS, HALT_OFS};
  assign mmio = 1'b0;
  assign con_valid = 1'b0;
  assign con_data = '0;
  assign halt = 1'b0;
`endif
  cpu_store_buffer #(.SB_DEPTH(SB_DEPTH)) u_sb (
    .clk(clk),
    .reset(reset),
    .push(cpu_we && aligned && !mmio),
    .stall(ld_en),
    .push_idx(idx),
    .push_data(cpu_wdata),
    .lookup_idx(idx),
    .drain(drain),
    .drop(drop),
    .hit(hit),
    .hit_data(hit_data),
    .head_entry(head_entry),
    .count(sb_count),
    .full(sb_full)
  );
  assign cpu_rdata = mmio ? {31'b0, halt} : hit ? hit_data : ram[idx];
  // loader has priority over the buffer drain for the single RAM write port
  always_ff @(posedge clk)
    if (ld_en) ram[ld_addr] <= ld_data;
    else if (drain) ram[head_entry.idx] <= head_entry.data;
  // sticky error flags
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      overflow <= 1'b0;
      err_misaligned <= 1'b0;
    end else begin
      overflow <= overflow | drop;
      err_misaligned <= err_misaligned | (cpu_we & ~aligned);
    end
endmodule
